// File: rtl/pingpong_pkg.sv
// Shared types and width helpers for the ping-pong symbol buffer.
package pingpong_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        SHIFT = 2'd3
    } rd_state_t;

    // Width of one packed RAM word.
    function automatic int unsigned word_w(input int unsigned sym_w, input int unsigned spw);
        return sym_w * spw;
    endfunction

    // Bits needed to hold a count from 0 to n inclusive.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with registered output.
module sdp_ram #(
    parameter int unsigned WIDTH = 49,
    parameter int unsigned AW    = 16
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [0:(1 << AW) - 1];

    // Write port plus one-cycle registered read; no reset so it maps to block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/pingpong_symbol_buffer.sv
// Packs incoming symbols into words, fills two RAM banks alternately, and
// unpacks closed banks back into a symbol stream.
module pingpong_symbol_buffer
    import pingpong_pkg::*;
#(
    parameter int unsigned SYM_W         = 7,
    parameter int unsigned SYMS_PER_WORD = 7,
    parameter int unsigned DEPTH         = 32768
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [SYM_W-1:0] i_sym_data,
    input  logic             i_sym_valid,
    output logic             o_sym_ready,
    input  logic             i_flush,
    output logic [SYM_W-1:0] o_sym_data,
    output logic             o_sym_valid,
    input  logic             i_sym_ready,
    output logic [1:0]       o_bank_full
);

    localparam int unsigned WORD_W = word_w(SYM_W, SYMS_PER_WORD);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned SCNT_W = cnt_w(SYMS_PER_WORD);
    localparam int unsigned WCNT_W = cnt_w(DEPTH);
    localparam logic [SCNT_W-1:0] SPW_C     = SCNT_W'(SYMS_PER_WORD);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    // Write side state
    logic              wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic [SCNT_W-1:0] wr_cnt;
    logic [WORD_W-1:0] wr_word;
    logic [WCNT_W-1:0] word_count [2];
    logic [SCNT_W-1:0] last_syms  [2];
    logic [1:0]        bank_full;

    // Write side decode
    logic              wr_accept;
    logic              wr_word_done;
    logic              wr_flush;
    logic              wr_close;
    logic              ram_we;
    logic [SCNT_W-1:0] wr_cnt_nxt;
    logic [SCNT_W-1:0] wr_last;
    logic [WORD_W-1:0] wr_word_nxt;
    logic [WCNT_W-1:0] wr_count;
    logic [1:0]        wr_set;

    // Read side state and decode
    rd_state_t         rd_state;
    rd_state_t         rd_state_nxt;
    logic              rd_bank;
    logic [ADDR_W-1:0] rd_addr;
    logic [SCNT_W-1:0] rd_idx;
    logic [WORD_W-1:0] shift_reg;
    logic [WORD_W-1:0] ram_rdata;
    logic              rd_load;
    logic              rd_shift;
    logic              rd_adv;
    logic              rd_done;
    logic              rd_final_word;
    logic              rd_last_sym;
    logic [SCNT_W-1:0] rd_limit;
    logic [1:0]        rd_clr;

    assign o_sym_ready = ~bank_full[wr_bank];
    assign o_bank_full = bank_full;
    assign o_sym_data  = shift_reg[WORD_W-1 -: SYM_W];

    // Write-side decode: pack symbol, detect word completion, flush and bank close.
    always_comb begin
        wr_accept    = i_sym_valid & o_sym_ready;
        wr_cnt_nxt   = wr_cnt + SCNT_W'(wr_accept);
        wr_word_nxt  = wr_word;
        if (wr_accept) begin
            wr_word_nxt = wr_word
                | (WORD_W'(i_sym_data) << ((SYMS_PER_WORD - 1 - 32'(wr_cnt)) * SYM_W));
        end
        wr_word_done = wr_accept & (wr_cnt == (SPW_C - SCNT_W'(1)));
        wr_flush     = i_flush & o_sym_ready & ((wr_cnt_nxt != '0) | (wr_addr != '0));
        ram_we       = wr_word_done | (wr_flush & (wr_cnt_nxt != '0));
        wr_close     = (wr_word_done & (wr_addr == LAST_ADDR)) | wr_flush;
        wr_count     = WCNT_W'(wr_addr) + WCNT_W'(ram_we);
        wr_last      = (wr_cnt_nxt == '0) ? SPW_C : wr_cnt_nxt;
        wr_set       = wr_close ? (2'b01 << wr_bank) : 2'b00;
    end

    // Write-side registers: address, partial word, per-bank close records.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_bank       <= 1'b0;
            wr_addr       <= '0;
            wr_cnt        <= '0;
            wr_word       <= '0;
            word_count[0] <= '0;
            word_count[1] <= '0;
            last_syms[0]  <= '0;
            last_syms[1]  <= '0;
        end else if (wr_close) begin
            wr_bank             <= ~wr_bank;
            wr_addr             <= '0;
            wr_cnt              <= '0;
            wr_word             <= '0;
            word_count[wr_bank] <= wr_count;
            last_syms[wr_bank]  <= wr_last;
        end else if (ram_we) begin
            wr_addr <= wr_addr + ADDR_W'(1);
            wr_cnt  <= '0;
            wr_word <= '0;
        end else if (wr_accept) begin
            wr_cnt  <= wr_cnt_nxt;
            wr_word <= wr_word_nxt;
        end
    end

    // Full flags: writer sets the bank it closes, reader clears the bank it drains.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            bank_full <= 2'b00;
        end else begin
            bank_full <= (bank_full & ~rd_clr) | wr_set;
        end
    end

    sdp_ram #(
        .WIDTH (WORD_W),
        .AW    (ADDR_W + 1)
    ) u_ram (
        .clk   (i_clk),
        .we    (ram_we),
        .waddr ({wr_bank, wr_addr}),
        .wdata (wr_word_nxt),
        .raddr ({rd_bank, rd_addr}),
        .rdata (ram_rdata)
    );

    // Read FSM state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rd_state <= IDLE;
        end else begin
            rd_state <= rd_state_nxt;
        end
    end

    // Read FSM next state and datapath controls.
    always_comb begin
        rd_state_nxt  = rd_state;
        rd_load       = 1'b0;
        rd_shift      = 1'b0;
        rd_adv        = 1'b0;
        rd_done       = 1'b0;
        rd_final_word = ((WCNT_W'(rd_addr) + WCNT_W'(1)) == word_count[rd_bank]);
        rd_limit      = rd_final_word ? last_syms[rd_bank] : SPW_C;
        rd_last_sym   = ((rd_idx + SCNT_W'(1)) == rd_limit);
        case (rd_state)
            IDLE: begin
                if (bank_full[rd_bank]) begin
                    rd_state_nxt = FETCH;
                end
            end
            FETCH: begin
                rd_state_nxt = LOAD;
            end
            LOAD: begin
                rd_load      = 1'b1;
                rd_state_nxt = SHIFT;
            end
            SHIFT: begin
                if (i_sym_ready) begin
                    if (!rd_last_sym) begin
                        rd_shift = 1'b1;
                    end else if (rd_final_word) begin
                        rd_done      = 1'b1;
                        rd_state_nxt = IDLE;
                    end else begin
                        rd_adv       = 1'b1;
                        rd_state_nxt = FETCH;
                    end
                end
            end
            default: begin
                rd_state_nxt = IDLE;
            end
        endcase
        rd_clr = rd_done ? (2'b01 << rd_bank) : 2'b00;
    end

    // Read datapath: word capture, symbol shifting, address and bank advance.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rd_bank     <= 1'b0;
            rd_addr     <= '0;
            rd_idx      <= '0;
            shift_reg   <= '0;
            o_sym_valid <= 1'b0;
        end else if (rd_load) begin
            shift_reg   <= ram_rdata;
            rd_idx      <= '0;
            o_sym_valid <= 1'b1;
        end else if (rd_shift) begin
            shift_reg <= shift_reg << SYM_W;
            rd_idx    <= rd_idx + SCNT_W'(1);
        end else if (rd_adv) begin
            rd_addr     <= rd_addr + ADDR_W'(1);
            o_sym_valid <= 1'b0;
        end else if (rd_done) begin
            rd_addr     <= '0;
            rd_bank     <= ~rd_bank;
            o_sym_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pingpong_symbol_buffer.sv
// Self-checking bench for pingpong_symbol_buffer with a symbol-level bank model.
module tb_pingpong_symbol_buffer;

    localparam int unsigned SYM_W = 7;
    localparam int unsigned SPW   = 7;
    localparam int unsigned DEPTH = 4;
    localparam int          CAP   = SPW * DEPTH;

    logic             clk = 1'b0;
    logic             i_reset;
    logic [SYM_W-1:0] i_sym_data;
    logic             i_sym_valid;
    logic             o_sym_ready;
    logic             i_flush;
    logic [SYM_W-1:0] o_sym_data;
    logic             o_sym_valid;
    logic             i_sym_ready;
    logic [1:0]       o_bank_full;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Model: symbols held per bank, full flags, write and read bank pointers
    bit m_full [2];
    int m_cnt  [2];
    int m_wb;
    int m_rb;
    int unsigned exp_q [$];
    int unsigned got_q [$];
    int          got_t [$];

    always #5 clk = ~clk;

    pingpong_symbol_buffer #(
        .SYM_W         (SYM_W),
        .SYMS_PER_WORD (SPW),
        .DEPTH         (DEPTH)
    ) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_sym_data  (i_sym_data),
        .i_sym_valid (i_sym_valid),
        .o_sym_ready (o_sym_ready),
        .i_flush     (i_flush),
        .o_sym_data  (o_sym_data),
        .o_sym_valid (o_sym_valid),
        .i_sym_ready (i_sym_ready),
        .o_bank_full (o_bank_full)
    );

    function automatic logic [1:0] m_flags();
        return {m_full[1], m_full[0]};
    endfunction

    task automatic model_clear();
        m_full[0] = 0; m_full[1] = 0;
        m_cnt[0]  = 0; m_cnt[1]  = 0;
        m_wb = 0; m_rb = 0;
    endtask

    task automatic clear_streams();
        exp_q.delete(); got_q.delete(); got_t.delete();
    endtask

    function automatic int first_diff();
        int n;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (got_q[i] != exp_q[i]) return i;
        end
        if (got_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    // One clock: drive at negedge, capture read handshake, step model on the edge.
    task automatic tick(input bit v, input logic [SYM_W-1:0] d, input bit fl, input bit rdy);
        bit ready, wacc, racc, close;
        int n;
        i_sym_valid = v; i_sym_data = d; i_flush = fl; i_sym_ready = rdy;
        ready = !m_full[m_wb];
        wacc  = v && ready;
        racc  = o_sym_valid && rdy;
        if (racc) begin
            got_q.push_back(int'(o_sym_data));
            got_t.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        if (racc && m_full[m_rb]) begin
            m_cnt[m_rb]--;
            if (m_cnt[m_rb] == 0) begin
                m_full[m_rb] = 0;
                m_rb ^= 1;
            end
        end
        if (wacc) begin
            exp_q.push_back(int'(d));
            m_cnt[m_wb]++;
        end
        n = m_cnt[m_wb];
        close = (wacc && n == CAP) || (fl && ready && n > 0);
        if (close) begin
            m_full[m_wb] = 1;
            m_wb ^= 1;
        end
        @(negedge clk);
        i_sym_valid = 1'b0;
        i_flush     = 1'b0;
    endtask

    task automatic drain(input int maxc, output bit to);
        int c = 0;
        while ((m_full[0] || m_full[1] || got_q.size() < exp_q.size()) && c < maxc) begin
            tick(0, '0, 0, 1);
            c++;
        end
        to = (c >= maxc);
        repeat (5) tick(0, '0, 0, 1);
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_sym_valid = 1'b0; i_sym_data = '0; i_flush = 1'b0; i_sym_ready = 1'b0;
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
        model_clear();
        clear_streams();
        @(negedge clk);
        tests++; if (o_sym_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", o_sym_ready); end
        tests++; if (o_sym_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", o_sym_valid); end
        tests++; if (o_bank_full !== 2'b00) begin fails++; $display("FAIL reset_full got %b want 00", o_bank_full); end
        tests++; if (o_sym_data !== '0) begin fails++; $display("FAIL reset_data got %0d want 0", o_sym_data); end
    endtask

    task automatic test_fill_one_bank();
        int lat;
        bit to;
        int d;
        clear_streams();
        for (int i = 0; i < CAP; i++) tick(1, SYM_W'(i), 0, 1);
        tests++; if (o_bank_full !== 2'b01) begin fails++; $display("FAIL fill_full got %b want 01", o_bank_full); end
        lat = 0;
        while (!o_sym_valid && lat < 10) begin tick(0, '0, 0, 1); lat++; end
        tests++; if (lat !== 3) begin fails++; $display("FAIL fill_latency got %0d want 3", lat); end
        drain(200, to);
        tests++; if (to) begin fails++; $display("FAIL fill_drain_timeout got timeout want drained"); end
        d = first_diff();
        tests++; if (d !== -1) begin fails++; $display("FAIL fill_stream first diff at %0d got_n %0d want_n %0d", d, got_q.size(), exp_q.size()); end
        tests++;
        if (got_t.size() < 8 || got_t[1] - got_t[0] != 1 || got_t[7] - got_t[6] != 3) begin
            fails++; $display("FAIL fill_gap got n=%0d want in-word step 1 and word step 3", got_t.size());
        end
        tests++; if (o_bank_full !== 2'b00) begin fails++; $display("FAIL fill_empty got %b want 00", o_bank_full); end
    endtask

    task automatic test_both_full();
        bit to;
        int d;
        clear_streams();
        for (int i = 0; i < 2 * CAP; i++) tick(1, SYM_W'(i), 0, 0);
        tests++; if (o_bank_full !== 2'b11) begin fails++; $display("FAIL both_full got %b want 11", o_bank_full); end
        tests++; if (o_sym_ready !== 1'b0) begin fails++; $display("FAIL both_ready got %b want 0", o_sym_ready); end
        for (int k = 0; k < 5; k++) begin
            tick(1, SYM_W'(2 * CAP), 0, 0);
            tests++;
            if (o_sym_valid !== 1'b1 || o_sym_data !== SYM_W'(0)) begin
                fails++; $display("FAIL both_hold valid %b data %0d want valid 1 data 0", o_sym_valid, o_sym_data);
            end
        end
        tests++; if (o_bank_full !== 2'b11) begin fails++; $display("FAIL both_full_hold got %b want 11", o_bank_full); end
        drain(400, to);
        tests++; if (to) begin fails++; $display("FAIL both_drain_timeout got timeout want drained"); end
        d = first_diff();
        tests++; if (d !== -1) begin fails++; $display("FAIL both_stream first diff at %0d got_n %0d want_n %0d", d, got_q.size(), exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit to;
        int d;
        clear_streams();
        for (int i = 0; i < 2 * CAP; i++) tick(1, SYM_W'($urandom), 0, 0);
        tick(0, '0, 0, 0);
        i_reset = 1'b1;
        #1;
        tests++; if (o_sym_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_valid got %b want 0", o_sym_valid); end
        tests++; if (o_bank_full !== 2'b00) begin fails++; $display("FAIL rst_mid_full got %b want 00", o_bank_full); end
        @(negedge clk);
        i_reset = 1'b0;
        model_clear();
        clear_streams();
        @(negedge clk);
        tests++; if (o_sym_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_ready got %b want 1", o_sym_ready); end
        for (int i = 0; i < 7; i++) tick(1, SYM_W'($urandom), 0, 1);
        tick(0, '0, 1, 1);
        tests++; if (o_bank_full !== 2'b01) begin fails++; $display("FAIL rst_mid_close got %b want 01", o_bank_full); end
        drain(200, to);
        d = first_diff();
        tests++; if (to || d !== -1) begin fails++; $display("FAIL rst_mid_stream timeout %0b diff at %0d got_n %0d want_n %0d", to, d, got_q.size(), exp_q.size()); end
    endtask

    task automatic test_flush_partial();
        bit to;
        int d, b;
        clear_streams();
        b = m_wb;
        for (int i = 0; i < 10; i++) tick(1, SYM_W'(i), 0, 1);
        tick(0, '0, 1, 1);
        tests++; if (o_bank_full !== m_flags()) begin fails++; $display("FAIL flush_full got %b want %b", o_bank_full, m_flags()); end
        tests++; if (dut.word_count[b] !== 3'd2) begin fails++; $display("FAIL flush_word_count got %0d want 2", dut.word_count[b]); end
        tests++; if (dut.last_syms[b] !== 3'd3) begin fails++; $display("FAIL flush_last_syms got %0d want 3", dut.last_syms[b]); end
        drain(200, to);
        d = first_diff();
        tests++; if (to || d !== -1) begin fails++; $display("FAIL flush_stream timeout %0b diff at %0d got_n %0d want_n 10", to, d, got_q.size()); end
    endtask

    task automatic test_flush_edges();
        bit to;
        int d, b;
        clear_streams();
        tick(0, '0, 1, 1);
        repeat (4) tick(0, '0, 0, 1);
        tests++; if (o_bank_full !== 2'b00) begin fails++; $display("FAIL flush_empty_full got %b want 00", o_bank_full); end
        tests++; if (got_q.size() !== 0) begin fails++; $display("FAIL flush_empty_out got %0d symbols want 0", got_q.size()); end
        b = m_wb;
        for (int i = 0; i < 6; i++) tick(1, SYM_W'($urandom), 0, 1);
        tick(1, SYM_W'($urandom), 1, 1);
        tests++; if (o_bank_full !== m_flags()) begin fails++; $display("FAIL flush_same_full got %b want %b", o_bank_full, m_flags()); end
        tests++; if (dut.last_syms[b] !== 3'd7 || dut.word_count[b] !== 3'd1) begin
            fails++; $display("FAIL flush_same_record got last %0d words %0d want 7 1", dut.last_syms[b], dut.word_count[b]);
        end
        drain(200, to);
        d = first_diff();
        tests++; if (to || d !== -1) begin fails++; $display("FAIL flush_same_stream timeout %0b diff at %0d got_n %0d want_n %0d", to, d, got_q.size(), exp_q.size()); end
    endtask

    task automatic test_random_stream();
        bit to, v, rdy, fl, acc;
        int d, c, sent, bad;
        clear_streams();
        sent = 0; c = 0; bad = 0;
        while (sent < 500 && c < 20000) begin
            v   = ($urandom_range(0, 9) < 7);
            rdy = ($urandom_range(0, 9) < 6);
            fl  = ($urandom_range(0, 39) == 0);
            acc = v && !m_full[m_wb];
            tick(v, SYM_W'($urandom), fl, rdy);
            if (acc) sent++;
            c++;
            tests++;
            if (o_bank_full !== m_flags() || o_sym_ready !== !m_full[m_wb]) begin
                fails++; bad++;
                if (bad <= 5) $display("FAIL rand_flags cyc %0d full %b ready %b want %b %b", c, o_bank_full, o_sym_ready, m_flags(), !m_full[m_wb]);
            end
        end
        tests++; if (c >= 20000) begin fails++; $display("FAIL rand_budget got %0d accepted want 500", sent); end
        tick(0, '0, 1, 1);
        drain(2000, to);
        d = first_diff();
        tests++; if (to || d !== -1) begin fails++; $display("FAIL rand_stream timeout %0b diff at %0d got_n %0d want_n %0d", to, d, got_q.size(), exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_fill_one_bank();
        test_both_full();
        test_reset_mid();
        test_flush_partial();
        test_flush_edges();
        test_random_stream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
